mem_refill_ctrl: RTL and testbench
==================================

MEM_REFILL_CTRL -- requirements
Module: mem_refill_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, word width; ADDR_WIDTH, default 32, byte address width; WORDS_PER_LINE, default 4, power of two ≥2, cache line length in words.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  the one clock
- reset  in  1  synchronous, active-low reset
- miss_valid  in  1  data cache miss pending; level, held until refill_done
- miss_addr  in  ADDR_WIDTH  byte address of the missing access
- victim_dirty  in  1  evicted line needs write-back
- victim_addr  in  ADDR_WIDTH  byte address of the victim line
- victim_data  in  WORDS_PER_LINE*DATA_WIDTH  victim line; word i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- cache_miss  out  1  pipeline stall request
- refill_we  out  1  write one refill word into the cache
- refill_idx  out  log2(WORDS_PER_LINE)  word index of the refill word
- refill_data  out  DATA_WIDTH  refill word
- refill_done  out  1  one-cycle pulse: line complete
- mem_req  out  1  memory beat request
- mem_we  out  1  1 = write beat, 0 = read beat
- mem_addr  out  ADDR_WIDTH  beat byte address
- mem_wdata  out  DATA_WIDTH  write beat data
- mem_ready  in  1  beat accepted (write) or mem_rdata valid (read)
- mem_rdata  in  DATA_WIDTH  read beat data
- miss_count  out  32  completed-refill counter

Function
REQ-003 The block SHALL be a Moore FSM with states IDLE, WRITEBACK, REFILL and DONE.
REQ-004 In IDLE with miss_valid=1, the next state SHALL be WRITEBACK if victim_dirty=1, otherwise REFILL.
- On this transition the block SHALL register the line base of each address (low log2(WORDS_PER_LINE*DATA_WIDTH/8) bits forced to 0).
- On this transition the block SHALL capture victim_data.
- The beat index SHALL be cleared to 0.
REQ-005 A beat SHALL complete on a clock edge where mem_req=1 and mem_ready=1. While mem_req=1, mem_addr, mem_we and mem_wdata SHALL stay stable until the beat completes.
REQ-006 mem_ready SHALL be ignored while mem_req=0.
REQ-007 WRITEBACK behaviour:
- mem_req=1, mem_we=1.
- mem_addr = victim base + 4*idx; mem_wdata = captured victim word idx.
- After beat WORDS_PER_LINE-1 completes: go to REFILL with idx=0.
REQ-008 REFILL behaviour:
- mem_req=1, mem_we=0, mem_addr = miss base + 4*idx.
- refill_we = mem_ready, combinationally, in the same cycle.
- refill_idx = idx; refill_data = mem_rdata.
- After the last beat completes: go to DONE.
REQ-009 DONE SHALL last exactly one cycle with refill_done=1 and mem_req=0, then return to IDLE.
REQ-010 cache_miss SHALL equal miss_valid AND NOT refill_done, combinationally, so the stall is asserted in the same cycle the miss appears.
REQ-011 Outside REFILL, refill_we SHALL be 0. Outside WRITEBACK and REFILL, mem_req and mem_we SHALL be 0.
REQ-012 Latency with mem_ready held at 1:
- Clean miss seen at cycle 0: refill beats at cycles 1..W, refill_done at cycle W+1.
- Dirty miss: refill_done at cycle 2W+1.
REQ-013 Once a transaction has started, it SHALL run to DONE even if miss_valid falls.
REQ-014 A miss_valid still high in the cycle after DONE SHALL start a new transaction.
REQ-015 Beat addresses SHALL never cross the line base, because the base is line-aligned. Arithmetic SHALL be modulo 2^ADDR_WIDTH.

Reset
REQ-016 At a clk edge with reset=0, the block SHALL:
- set the state to IDLE and idx to 0;
- clear the captured addresses and data;
- drive mem_req, mem_we, refill_we and refill_done to 0;
- clear miss_count.
REQ-017 A reset asserted mid-transfer SHALL abandon the transfer, with mem_req=0 from the next cycle. No partial completion SHALL be signalled.

Configuration
REQ-018 With macro MEM_REFILL_PERF_COUNT_EN defined, miss_count SHALL increment by 1 in each DONE cycle and saturate at 0xFFFFFFFF.
REQ-019 Without MEM_REFILL_PERF_COUNT_EN, miss_count SHALL be tied to 0 and no counter register SHALL be inferred. All other behaviour SHALL be identical.

Verification
REQ-020 Clean miss: miss_addr=0x0000_1234, victim_dirty=0, mem_ready=1 → 4 read beats at 0x1230, 0x1234, 0x1238, 0x123C with refill_idx 0..3; refill_done at cycle 5; cache_miss=1 cycles 0..4, 0 at cycle 5.
REQ-021 Dirty miss: victim_addr=0x0000_2000, victim_data words 0xA0..0xA3, miss_addr=0x3000 → writes 0xA0..0xA3 to 0x2000..0x200C, then reads 0x3000..0x300C; refill_done at cycle 9.
REQ-022 Backpressure: mem_ready=1 only on every third cycle during a clean refill → mem_addr and mem_we stable between beats; exactly 4 refill_we pulses; refill_done 13 cycles after the miss.
REQ-023 Reset mid-refill: reset=0 after 2 read beats → next cycle IDLE, mem_req=0, refill_done never pulses; a fresh miss afterwards completes normally.
REQ-024 Counter (macro defined): 3 back-to-back clean misses → miss_count=3. With the macro undefined, the same stimulus → miss_count stays 0.

Source files
------------

// File: rtl/mem_refill_ctrl.sv
// mem_refill_ctrl: data-cache line write-back/refill FSM; define MEM_REFILL_PERF_COUNT_EN to enable the saturating miss_count
module mem_refill_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 miss_valid,
  input  logic [ADDR_WIDTH-1:0]                miss_addr,
  input  logic                                 victim_dirty,
  input  logic [ADDR_WIDTH-1:0]                victim_addr,
  input  logic [WORDS_PER_LINE*DATA_WIDTH-1:0] victim_data,
  output logic                                 cache_miss,
  output logic                                 refill_we,
  output logic [$clog2(WORDS_PER_LINE)-1:0]    refill_idx,
  output logic [DATA_WIDTH-1:0]                refill_data,
  output logic                                 refill_done,
  output logic                                 mem_req,
  output logic                                 mem_we,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  output logic [DATA_WIDTH-1:0]                mem_wdata,
  input  logic                                 mem_ready,
  input  logic [DATA_WIDTH-1:0]                mem_rdata,
  output logic [31:0]                          miss_count
);
  localparam int IW = $clog2(WORDS_PER_LINE);
  localparam int LW = WORDS_PER_LINE * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LW / 8 - 1);
  localparam logic [1:0] IDLE = 2'd0, WRITEBACK = 2'd1, REFILL = 2'd2, DONE = 2'd3;
  logic [1:0] state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] miss_base_q, victim_base_q;
  logic [LW-1:0] victim_data_q;
  logic beat, last;
  // Moore outputs from state; refill write strobe follows mem_ready in the same cycle
  always_comb begin
    mem_req     = (state_q == WRITEBACK) || (state_q == REFILL);
    mem_we      = state_q == WRITEBACK;
    mem_addr    = (mem_we ? victim_base_q : miss_base_q) + ADDR_WIDTH'({idx_q, 2'b00});
    mem_wdata   = victim_data_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
    refill_we   = (state_q == REFILL) && mem_ready;
    refill_idx  = idx_q;
    refill_data = mem_rdata;
    refill_done = state_q == DONE;
    cache_miss  = miss_valid && !refill_done;
  end
  // next state: a beat completes on req&ready; index wraps to 0 after the last word
  always_comb begin
    beat    = mem_req && mem_ready;
    last    = beat && (&idx_q);
    idx_d   = (state_q == IDLE) ? '0 : beat ? idx_q + IW'(1) : idx_q;
    state_d = (state_q == IDLE)      ? (miss_valid ? (victim_dirty ? WRITEBACK : REFILL) : IDLE) :
              (state_q == WRITEBACK) ? (last ? REFILL : WRITEBACK) :
              (state_q == REFILL)    ? (last ? DONE : REFILL) : IDLE;
  end
  // state, beat index and line-aligned capture of the miss/victim at transaction start
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      miss_base_q   <= '0;
      victim_base_q <= '0;
      victim_data_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == IDLE && miss_valid) begin
        miss_base_q   <= miss_addr & LINE_MASK;
        victim_base_q <= victim_addr & LINE_MASK;
        victim_data_q <= victim_data;
      end
    end
  end
`ifdef MEM_REFILL_PERF_COUNT_EN
  logic [31:0] miss_count_q;
  // completed refills, saturating at all-ones
  always_ff @(posedge clk) begin
    if (!reset) miss_count_q <= '0;
    else if (state_q == DONE && !(&miss_count_q)) miss_count_q <= miss_count_q + 32'd1;
  end
  assign miss_count = miss_count_q;
`else
  assign miss_count = 32'd0;
`endif
endmodule

// File: tb/tb_mem_refill_ctrl.sv
// tb_mem_refill_ctrl: directed checks of refill latency, write-back, backpressure, reset abort and miss counter
module tb_mem_refill_ctrl;
  localparam int DW = 32, AW = 32, W = 4;
`ifdef MEM_REFILL_PERF_COUNT_EN
  localparam int INC = 1;
`else
  localparam int INC = 0;
`endif
  logic clk = 1'b0, reset = 1'b0, miss_valid = 1'b0, victim_dirty = 1'b0, mem_ready = 1'b0;
  logic [AW-1:0] miss_addr = '0, victim_addr = '0;
  logic [W*DW-1:0] victim_data = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic cache_miss, refill_we, refill_done, mem_req, mem_we;
  logic [1:0] refill_idx;
  logic [DW-1:0] refill_data, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [31:0] miss_count;
  int tests = 0, fails = 0, nwe = 0;

  mem_refill_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORDS_PER_LINE(W)) dut (
    .clk(clk), .reset(reset), .miss_valid(miss_valid), .miss_addr(miss_addr),
    .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_data(victim_data),
    .cache_miss(cache_miss), .refill_we(refill_we), .refill_idx(refill_idx),
    .refill_data(refill_data), .refill_done(refill_done), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    cyc(); cyc(); #1;
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_rwe", refill_we, 0);
    chk("rst_done", refill_done, 0);
    chk("rst_cnt", miss_count, 0);
    cyc(); reset = 1'b1; #1;
    chk("idle_req", mem_req, 0);
    // clean miss
    cyc(); miss_valid = 1'b1; miss_addr = 32'h1234; victim_dirty = 1'b0; mem_ready = 1'b1; #1;
    chk("clean_c0_stall", cache_miss, 1);
    chk("clean_c0_req", mem_req, 0);
    for (int c = 1; c <= 4; c++) begin
      cyc(); mem_rdata = 32'hD0 + c; #1;
      chk("clean_req", mem_req, 1);
      chk("clean_we", mem_we, 0);
      chk("clean_addr", mem_addr, 32'h1230 + 4 * (c - 1));
      chk("clean_rwe", refill_we, 1);
      chk("clean_idx", refill_idx, c - 1);
      chk("clean_rdata", refill_data, 32'hD0 + c);
      chk("clean_stall", cache_miss, 1);
      chk("clean_done_early", refill_done, 0);
    end
    cyc(); #1;
    chk("clean_done", refill_done, 1);
    chk("clean_c5_stall", cache_miss, 0);
    chk("clean_c5_req", mem_req, 0);
    chk("clean_c5_rwe", refill_we, 0);
    cyc(); miss_valid = 1'b0; #1;
    chk("clean_c6_done", refill_done, 0);
    chk("clean_c6_req", mem_req, 0);
    // dirty miss, with miss_valid dropped mid-transfer
    cyc(); miss_valid = 1'b1; victim_dirty = 1'b1; victim_addr = 32'h2000; miss_addr = 32'h300C;
    victim_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0}; #1;
    chk("dirty_c0_req", mem_req, 0);
    for (int c = 1; c <= 4; c++) begin
      cyc(); victim_data = '1; if (c == 3) miss_valid = 1'b0; #1;
      chk("wb_req", mem_req, 1);
      chk("wb_we", mem_we, 1);
      chk("wb_addr", mem_addr, 32'h2000 + 4 * (c - 1));
      chk("wb_wdata", mem_wdata, 32'hA0 + c - 1);
      chk("wb_rwe", refill_we, 0);
    end
    chk("dirty_stall_dropped", cache_miss, 0);
    for (int c = 5; c <= 8; c++) begin
      cyc(); mem_rdata = 32'hE0 + c; #1;
      chk("rd_we", mem_we, 0);
      chk("rd_addr", mem_addr, 32'h3000 + 4 * (c - 5));
      chk("rd_rwe", refill_we, 1);
      chk("rd_idx", refill_idx, c - 5);
      chk("rd_done_early", refill_done, 0);
    end
    cyc(); #1;
    chk("dirty_done", refill_done, 1);
    chk("dirty_done_req", mem_req, 0);
    cyc(); #1;
    chk("dirty_c10_idle", mem_req, 0);
    // backpressure: ready on every third cycle
    cyc(); miss_valid = 1'b1; miss_addr = 32'h1234; victim_dirty = 1'b0; mem_ready = 1'b1; #1;
    chk("bp_c0_stall", cache_miss, 1);
    nwe = 0;
    for (int c = 1; c <= 12; c++) begin
      cyc(); mem_ready = (c % 3 == 0); mem_rdata = c; #1;
      chk("bp_req", mem_req, 1);
      chk("bp_we", mem_we, 0);
      chk("bp_addr", mem_addr, 32'h1230 + 4 * ((c - 1) / 3));
      chk("bp_rwe", refill_we, mem_ready);
      chk("bp_done_early", refill_done, 0);
      nwe += int'(refill_we);
    end
    chk("bp_pulses", nwe, 4);
    cyc(); mem_ready = 1'b1; #1;
    chk("bp_done", refill_done, 1);
    cyc(); miss_valid = 1'b0; #1;
    chk("bp_idle", mem_req, 0);
    // reset after two read beats
    cyc(); miss_valid = 1'b1; miss_addr = 32'h4000; mem_ready = 1'b1; #1;
    for (int c = 1; c <= 2; c++) begin
      cyc(); #1;
      chk("rm_rwe", refill_we, 1);
    end
    cyc(); reset = 1'b0; miss_valid = 1'b0; #1;
    cyc(); #1;
    chk("rm_req", mem_req, 0);
    chk("rm_rwe_off", refill_we, 0);
    chk("rm_done", refill_done, 0);
    for (int c = 5; c <= 8; c++) begin
      cyc(); reset = 1'b1; #1;
      chk("rm_no_done", refill_done, 0);
      chk("rm_no_req", mem_req, 0);
    end
    cyc(); miss_valid = 1'b1; miss_addr = 32'h501C; #1;
    for (int c = 1; c <= 4; c++) begin
      cyc(); #1;
      chk("rm2_addr", mem_addr, 32'h5010 + 4 * (c - 1));
      chk("rm2_rwe", refill_we, 1);
    end
    cyc(); #1;
    chk("rm2_done", refill_done, 1);
    cyc(); miss_valid = 1'b0; #1;
    // three back-to-back clean misses after a fresh reset
    cyc(); reset = 1'b0; #1;
    cyc(); #1;
    chk("cnt_rst", miss_count, 0);
    cyc(); reset = 1'b1; #1;
    for (int c = 0; c <= 17; c++) begin
      cyc(); miss_valid = 1'b1; miss_addr = 32'h6000 + 32'h40 * (c / 6); mem_ready = 1'b1; #1;
      chk("b2b_done", refill_done, (c % 6 == 5));
      chk("b2b_cnt", miss_count, INC * (c / 6));
    end
    cyc(); miss_valid = 1'b0; #1;
    chk("b2b_cnt_final", miss_count, 3 * INC);
    chk("b2b_idle", mem_req, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
